a1339_angle_tracker: RTL and testbench
======================================

# a1339_angle_tracker

- Multi-turn tracking stage between the A1339 SPI frame reader and the register bank.
- Takes raw single-turn angle samples, time-multiplexed across all sensors, and unwraps them into a multi-turn revolution count and absolute angle.
- Maintains a per-sensor zero offset and relative angle, and a windowed velocity.
- Drives the per-sensor angle arrays and the `cycle` strobes consumed by the sensor interface.

## Interface
Parameters:
- NUMBER_OF_SENSORS, 1, sensors served.
- ANGLE_BITS, 12, raw angle width; FULL = 2**ANGLE_BITS, HALF = FULL/2.
- VELOCITY_WINDOW, 50000, clock cycles per velocity window (≥2).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- sample_valid  in  1  raw sample present.
- sample_ready  out  1  tracker can accept a sample.
- sample_index  in  $clog2(NUMBER_OF_SENSORS) (min 1)  sensor number.
- sample_angle  in  ANGLE_BITS  raw unsigned angle.
- sample_error  in  1  frame CRC/error flag.
- zero_offset  in  1  level; capture current absolute as offset.
- sensor_angle  out  32 signed ×N  last raw angle, zero-extended.
- sensor_angle_absolute  out  32 signed ×N  rev·FULL + angle.
- sensor_angle_offset  out  32 signed ×N  captured offset.
- sensor_angle_relative  out  32 signed ×N  absolute − offset.
- sensor_angle_velocity  out  32 signed ×N  absolute change per window.
- sensor_revolution_counter  out  32 signed ×N  turns.
- cycle  out  N  one-cycle pulse per committed sensor update.

## Operation
- FSM with states IDLE → UNWRAP → COMMIT → IDLE.
  - sample_ready = 1 only in IDLE and not in reset.
  - A transfer is sample_valid & sample_ready; the input fields are registered on that edge.
- Discard rule: a transfer with sample_error = 1, or with sample_index ≥ NUMBER_OF_SENSORS, is consumed and discarded.
  - FSM stays in IDLE; no state or output changes; no cycle pulse.
- UNWRAP: delta = angle − prev_angle[i], computed signed at ANGLE_BITS+1 bits.
  - delta > HALF → rev−1.
  - delta < −HALF → rev+1.
  - |delta| = HALF → no revolution change.
- First-sample rule: after reset, the first valid sample of each sensor (tracked by per-sensor flag first[i]) does no unwrap; rev stays 0.
- COMMIT: write angle, rev, absolute = (rev<<ANGLE_BITS) + angle, and relative; store prev_angle[i]; pulse cycle[i].
- Arithmetic: all 32-bit two's complement; rev, absolute and relative wrap modulo 2^32 with no saturation.
- zero_offset:
  - Every cycle it is high, offset[i] ← absolute[i] for every sensor.
  - For the sensor committing in that cycle, offset takes the new absolute, so relative = 0.
- Velocity:
  - A free-running window counter counts 0..VELOCITY_WINDOW−1.
  - At terminal count, for all i: velocity[i] ← absolute[i] − snap[i], then snap[i] ← absolute[i].
  - These use the absolute register value before that edge, even if COMMIT writes the same edge.

## Timing
- Transfer on edge T. The UNWRAP computation happens in the cycle after T. Outputs and cycle[i] are updated on edge T+2, visible from T+2 on.
- sample_ready is low during UNWRAP and COMMIT, high again from T+2. Maximum throughput is one sample per 3 cycles.
- Reset (reset_n low at an edge):
  - All outputs, snap, prev_angle, rev and window counter → 0; first[] → 1; FSM → IDLE; cycle → 0.
  - sample_ready reads 0 while reset_n is low and returns to 1 the cycle after release.
  - Reset during UNWRAP/COMMIT aborts the in-flight sample with no commit.
- cycle bits are never high for more than one cycle; at most one bit is high per cycle.

## Structure
- Package a1339_tracker_pkg: state enum, FULL/HALF localparams as ANGLE_BITS functions, and the 32-bit signed angle typedef.
- Sub-module a1339_velocity_window: window counter plus per-sensor snapshot/difference registers, clock/reset_n only.

## Test plan
- Reset, then sensor 0 sample 1000 → cycle[0] at T+2; angle = absolute = relative = 1000, rev = 0.
- Sensor 0: 4000 then 100 → rev = 1, absolute = 4196. Then 4000 → rev = 0, absolute = 4000. Then 2048 (delta = −1952) → no rev change.
- From a reset state, sensor 0: 100 then 4000 → rev = −1, absolute = −96. Interleave sensor 1 samples and confirm sensor 1 is unaffected.
- At absolute 4196, hold zero_offset for 1 cycle → offset = 4196, relative = 0. Next sample 200 → absolute = 4296, relative = 100. Assert zero_offset in the COMMIT cycle → relative = 0.
- VELOCITY_WINDOW = 100; absolute 1000 at one window edge and 1500 at the next → velocity = 500. A commit coincident with the window edge uses the old value.
- Discard and reset cases:
  - sample_error = 1 or sample_index = N → no change, no cycle pulse.
  - reset_n low during UNWRAP → all outputs 0, no commit; the next sample is treated as first.

Source files
------------

// File: rtl/a1339_tracker_pkg.sv
// Shared types and helpers for the A1339 multi-turn angle tracker.
package a1339_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNWRAP = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    typedef logic signed [31:0] angle_t;

    // Counts per mechanical turn for a given raw angle width.
    function automatic int full_of(input int bits);
        return 32'sd1 <<< bits;
    endfunction

    function automatic int half_of(input int bits);
        return full_of(bits) / 32'sd2;
    endfunction

endpackage

// File: rtl/a1339_velocity_window.sv
// Free-running window counter; at each terminal count latches the per-sensor
// absolute change since the previous window edge.
module a1339_velocity_window
    import a1339_tracker_pkg::*;
#(
    parameter int NUMBER_OF_SENSORS = 1,
    parameter int VELOCITY_WINDOW   = 50000
) (
    input  logic   clock,
    input  logic   reset_n,
    input  angle_t absolute [NUMBER_OF_SENSORS],
    output angle_t velocity [NUMBER_OF_SENSORS]
);

    localparam int CW = $clog2(VELOCITY_WINDOW);

    logic [CW-1:0] count_r;
    angle_t        snap_r [NUMBER_OF_SENSORS];
    logic          terminal_s;

    assign terminal_s = (count_r == CW'(VELOCITY_WINDOW - 1));

    // Window counter plus snapshot/difference registers; absolute is the pre-edge value.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_r <= '0;
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                snap_r[i]   <= 32'sd0;
                velocity[i] <= 32'sd0;
            end
        end else begin
            if (terminal_s) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CW'(1);
            end
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                if (terminal_s) begin
                    velocity[i] <= absolute[i] - snap_r[i];
                    snap_r[i]   <= absolute[i];
                end else begin
                    velocity[i] <= velocity[i];
                    snap_r[i]   <= snap_r[i];
                end
            end
        end
    end

endmodule

// File: rtl/a1339_angle_tracker.sv
// Unwraps time-multiplexed single-turn A1339 samples into per-sensor
// multi-turn angle, zero offset, relative angle and windowed velocity.
module a1339_angle_tracker
    import a1339_tracker_pkg::*;
#(
    parameter int NUMBER_OF_SENSORS = 1,
    parameter int ANGLE_BITS        = 12,
    parameter int VELOCITY_WINDOW   = 50000,
    localparam int IW = (NUMBER_OF_SENSORS > 1) ? $clog2(NUMBER_OF_SENSORS) : 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic [IW-1:0]                sample_index,
    input  logic [ANGLE_BITS-1:0]        sample_angle,
    input  logic                         sample_error,
    input  logic                         zero_offset,
    output angle_t                       sensor_angle              [NUMBER_OF_SENSORS],
    output angle_t                       sensor_angle_absolute     [NUMBER_OF_SENSORS],
    output angle_t                       sensor_angle_offset       [NUMBER_OF_SENSORS],
    output angle_t                       sensor_angle_relative     [NUMBER_OF_SENSORS],
    output angle_t                       sensor_angle_velocity     [NUMBER_OF_SENSORS],
    output angle_t                       sensor_revolution_counter [NUMBER_OF_SENSORS],
    output logic [NUMBER_OF_SENSORS-1:0] cycle
);

    localparam int FULL = full_of(ANGLE_BITS);
    localparam int HALF = half_of(ANGLE_BITS);
    localparam angle_t FULL_S = angle_t'(FULL);
    localparam logic signed [ANGLE_BITS:0] HALF_S     = (ANGLE_BITS+1)'(HALF);
    localparam logic signed [ANGLE_BITS:0] NEG_HALF_S = -HALF_S;

    state_t                       state_r;
    logic                         ready_r;
    logic [IW-1:0]                idx_r;
    logic [ANGLE_BITS-1:0]        angle_r;
    angle_t                       rev_new_r;
    logic [ANGLE_BITS-1:0]        prev_angle_r [NUMBER_OF_SENSORS];
    logic [NUMBER_OF_SENSORS-1:0] first_r;

    logic                         transfer_s;
    logic                         discard_s;
    logic [ANGLE_BITS-1:0]        prev_sel_s;
    angle_t                       rev_sel_s;
    logic                         first_sel_s;
    logic signed [ANGLE_BITS:0]   delta_s;
    angle_t                       rev_calc_s;
    angle_t                       abs_new_s;
    logic [NUMBER_OF_SENSORS-1:0] commit_s;
    angle_t                       abs_next_s [NUMBER_OF_SENSORS];
    angle_t                       off_next_s [NUMBER_OF_SENSORS];

    assign sample_ready = ready_r & reset_n;
    assign transfer_s   = sample_valid & sample_ready;
    assign discard_s    = sample_error | (32'(sample_index) >= 32'(NUMBER_OF_SENSORS));
    assign delta_s      = $signed({1'b0, angle_r}) - $signed({1'b0, prev_sel_s});
    assign abs_new_s    = (rev_new_r * FULL_S) + angle_t'(32'(angle_r));

    // Select the history of the sensor currently being processed.
    always_comb begin
        prev_sel_s  = '0;
        rev_sel_s   = 32'sd0;
        first_sel_s = 1'b0;
        for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
            prev_sel_s  = prev_sel_s  | ((idx_r == IW'(i)) ? prev_angle_r[i] : '0);
            rev_sel_s   = rev_sel_s   | ((idx_r == IW'(i)) ? sensor_revolution_counter[i] : 32'sd0);
            first_sel_s = first_sel_s | ((idx_r == IW'(i)) & first_r[i]);
        end
    end

    // Exactly half a turn is ambiguous and is deliberately treated as no crossing.
    always_comb begin
        if (first_sel_s) begin
            rev_calc_s = rev_sel_s;
        end else if (delta_s > HALF_S) begin
            rev_calc_s = rev_sel_s - 32'sd1;
        end else if (delta_s < NEG_HALF_S) begin
            rev_calc_s = rev_sel_s + 32'sd1;
        end else begin
            rev_calc_s = rev_sel_s;
        end
    end

    // Next absolute/offset per sensor; a same-cycle zero capture sees the new absolute.
    always_comb begin
        for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
            commit_s[i]   = (state_r == ST_COMMIT) && (idx_r == IW'(i));
            abs_next_s[i] = commit_s[i] ? abs_new_s : sensor_angle_absolute[i];
            off_next_s[i] = zero_offset ? abs_next_s[i] : sensor_angle_offset[i];
        end
    end

    // Sample FSM and per-sensor output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            ready_r   <= 1'b0;
            idx_r     <= '0;
            angle_r   <= '0;
            rev_new_r <= 32'sd0;
            first_r   <= '1;
            cycle     <= '0;
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                prev_angle_r[i]              <= '0;
                sensor_angle[i]              <= 32'sd0;
                sensor_angle_absolute[i]     <= 32'sd0;
                sensor_angle_offset[i]       <= 32'sd0;
                sensor_angle_relative[i]     <= 32'sd0;
                sensor_revolution_counter[i] <= 32'sd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (transfer_s && !discard_s) begin
                        idx_r   <= sample_index;
                        angle_r <= sample_angle;
                        state_r <= ST_UNWRAP;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                ST_UNWRAP: begin
                    rev_new_r <= rev_calc_s;
                    state_r   <= ST_COMMIT;
                    ready_r   <= 1'b0;
                end
                ST_COMMIT: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                end
            endcase

            cycle <= commit_s;
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                sensor_angle_absolute[i] <= abs_next_s[i];
                sensor_angle_offset[i]   <= off_next_s[i];
                sensor_angle_relative[i] <= abs_next_s[i] - off_next_s[i];
                if (commit_s[i]) begin
                    sensor_angle[i]              <= angle_t'(32'(angle_r));
                    sensor_revolution_counter[i] <= rev_new_r;
                    prev_angle_r[i]              <= angle_r;
                    first_r[i]                   <= 1'b0;
                end else begin
                    sensor_angle[i]              <= sensor_angle[i];
                    sensor_revolution_counter[i] <= sensor_revolution_counter[i];
                    prev_angle_r[i]              <= prev_angle_r[i];
                    first_r[i]                   <= first_r[i];
                end
            end
        end
    end

    a1339_velocity_window #(
        .NUMBER_OF_SENSORS (NUMBER_OF_SENSORS),
        .VELOCITY_WINDOW   (VELOCITY_WINDOW)
    ) u_velocity (
        .clock    (clock),
        .reset_n  (reset_n),
        .absolute (sensor_angle_absolute),
        .velocity (sensor_angle_velocity)
    );

endmodule

// File: tb/tb_a1339_angle_tracker.sv
// Scoreboard bench for a1339_angle_tracker: directed samples push expected
// commits, a negedge monitor pops and compares on each cycle pulse.
module tb_a1339_angle_tracker;

    localparam int N = 3;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_valid = 1'b0;
    logic               sample_ready;
    logic [1:0]         sample_index = 2'd0;
    logic [11:0]        sample_angle = 12'd0;
    logic               sample_error = 1'b0;
    logic               zero_offset = 1'b0;
    logic signed [31:0] s_ang [N];
    logic signed [31:0] s_abs [N];
    logic signed [31:0] s_off [N];
    logic signed [31:0] s_rel [N];
    logic signed [31:0] s_vel [N];
    logic signed [31:0] s_rev [N];
    logic [N-1:0]       cycle;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rst_cyc = 0;

    typedef struct {
        int idx; int ang; int abs_v; int rev; int off; int rel; int at;
    } exp_t;
    exp_t sb[$];

    a1339_angle_tracker #(
        .NUMBER_OF_SENSORS (N),
        .ANGLE_BITS        (12),
        .VELOCITY_WINDOW   (100)
    ) dut (
        .clock                     (clock),
        .reset_n                   (reset_n),
        .sample_valid              (sample_valid),
        .sample_ready              (sample_ready),
        .sample_index              (sample_index),
        .sample_angle              (sample_angle),
        .sample_error              (sample_error),
        .zero_offset               (zero_offset),
        .sensor_angle              (s_ang),
        .sensor_angle_absolute     (s_abs),
        .sensor_angle_offset       (s_off),
        .sensor_angle_relative     (s_rel),
        .sensor_angle_velocity     (s_vel),
        .sensor_revolution_counter (s_rev),
        .cycle                     (cycle)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset_n) rst_cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every cycle pulse against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (cycle != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_cycle", 32'(cycle), 0);
            end else begin
                e = sb.pop_front();
                chk("cycle_bits", 32'(cycle), 32'(1) << e.idx);
                chk("commit_time", cyc, e.at);
                chk("angle", s_ang[e.idx], e.ang);
                chk("absolute", s_abs[e.idx], e.abs_v);
                chk("revolution", s_rev[e.idx], e.rev);
                chk("offset", s_off[e.idx], e.off);
                chk("relative", s_rel[e.idx], e.rel);
            end
        end else if (sb.size() != 0 && cyc > sb[0].at) begin
            chk("missing_commit", cyc, sb[0].at);
            void'(sb.pop_front());
        end
    end

    task automatic send(input int idx, input int ang, input int e_abs, input int e_rev,
                        input int e_off, input int e_rel, input bit zo);
        exp_t e;
        @(negedge clock);
        chk("ready_idle", 32'(sample_ready), 1);
        sample_valid = 1'b1;
        sample_index = 2'(idx);
        sample_angle = 12'(ang);
        sample_error = 1'b0;
        @(posedge clock); #1;
        sample_valid = 1'b0;
        e = '{idx, ang, e_abs, e_rev, e_off, e_rel, cyc + 2};
        sb.push_back(e);
        @(negedge clock);
        chk("ready_busy", 32'(sample_ready), 0);
        @(posedge clock);
        if (zo) begin
            @(negedge clock);
            zero_offset = 1'b1;
        end
        @(posedge clock); #1;
        zero_offset = 1'b0;
    endtask

    task automatic send_bad(input int idx, input int ang, input bit err);
        @(negedge clock);
        sample_valid = 1'b1;
        sample_index = 2'(idx);
        sample_angle = 12'(ang);
        sample_error = err;
        @(posedge clock); #1;
        sample_valid = 1'b0;
        sample_error = 1'b0;
        @(negedge clock);
        chk("ready_after_discard", 32'(sample_ready), 1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        sample_valid = 1'b0;
        zero_offset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("ready_in_reset", 32'(sample_ready), 0);
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < rst_cyc + n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic chk_zero(input int i);
        chk("rst_angle", s_ang[i], 0);
        chk("rst_abs", s_abs[i], 0);
        chk("rst_off", s_off[i], 0);
        chk("rst_rel", s_rel[i], 0);
        chk("rst_vel", s_vel[i], 0);
        chk("rst_rev", s_rev[i], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and first sample.
        do_reset();
        @(negedge clock);
        for (int i = 0; i < N; i++) chk_zero(i);
        chk("rst_cycle", 32'(cycle), 0);
        chk("ready_after_release", 32'(sample_ready), 1);
        send(0, 1000, 1000, 0, 0, 1000, 1'b0);

        // Forward/backward wrap, zero offset, discards.
        do_reset();
        send(0, 4000, 4000, 0, 0, 4000, 1'b0);
        send(0, 100, 4196, 1, 0, 4196, 1'b0);
        @(negedge clock); zero_offset = 1'b1;
        @(negedge clock); zero_offset = 1'b0;
        chk("zo_offset", s_off[0], 4196);
        chk("zo_relative", s_rel[0], 0);
        chk("zo_abs", s_abs[0], 4196);
        chk("zo_other_offset", s_off[1], 0);
        send(0, 200, 4296, 1, 4196, 100, 1'b0);
        send(0, 4000, 4000, 0, 4000, 0, 1'b1);
        send(0, 2048, 2048, 0, 4000, -1952, 1'b0);
        send_bad(0, 100, 1'b1);
        send_bad(3, 100, 1'b0);
        chk("discard_angle", s_ang[0], 2048);
        chk("discard_abs", s_abs[0], 2048);
        chk("discard_s1", s_abs[1], 0);
        send(0, 2100, 2100, 0, 4000, -1900, 1'b0);

        // Backward wrap, interleaved sensor, half-turn boundaries.
        do_reset();
        send(0, 100, 100, 0, 0, 100, 1'b0);
        send(1, 50, 50, 0, 0, 50, 1'b0);
        send(0, 4000, -96, -1, 0, -96, 1'b0);
        send(1, 4090, -6, -1, 0, -6, 1'b0);
        send(1, 10, 10, 0, 0, 10, 1'b0);
        chk("s0_kept_abs", s_abs[0], -96);
        chk("s0_kept_rev", s_rev[0], -1);
        chk("s2_untouched", s_abs[2], 0);
        send(0, 1952, -2144, -1, 0, -2144, 1'b0);
        send(0, 4000, -96, -1, 0, -96, 1'b0);

        // Reset during UNWRAP aborts the sample; next one is a first sample.
        do_reset();
        send(0, 500, 500, 0, 0, 500, 1'b0);
        @(negedge clock);
        sample_valid = 1'b1; sample_index = 2'd0; sample_angle = 12'd3000;
        @(posedge clock); #1;
        sample_valid = 1'b0;
        @(negedge clock); reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("abort_angle", s_ang[0], 0);
        chk("abort_abs", s_abs[0], 0);
        chk("abort_rev", s_rev[0], 0);
        chk("abort_ready", 32'(sample_ready), 1);
        send(0, 3500, 3500, 0, 0, 3500, 1'b0);

        // Velocity windows of 100 cycles.
        do_reset();
        send(0, 1000, 1000, 0, 0, 1000, 1'b0);
        wait_until(99);
        @(negedge clock); chk("vel_before_edge", s_vel[0], 0);
        wait_until(100);
        @(negedge clock); chk("vel_first", s_vel[0], 1000);
        send(0, 1500, 1500, 0, 0, 1500, 1'b0);
        wait_until(200);
        @(negedge clock); chk("vel_500", s_vel[0], 500);
        wait_until(297);
        send(0, 1800, 1800, 0, 0, 1800, 1'b0);
        @(negedge clock); chk("vel_coincident", s_vel[0], 0);
        wait_until(400);
        @(negedge clock); chk("vel_after", s_vel[0], 300);
        chk("vel_s1", s_vel[1], 0);

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
